// File: rtl/change_dispenser.sv
// Pays out one vending transaction (product, then change) one eject at a time; each eject waits for eject_done, first pulse 1 cycle after accept.
// Takes a request only when idle and fault-free; two fives stand in for a missing ten, and an infeasible, illegal or stalled payout latches fault.
module change_dispenser #(
    parameter int CNT_W     = 4,
    parameter int INIT_FIVE = 8,
    parameter int INIT_TEN  = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_prod,
    input  logic [1:0]       req_chg,
    output logic             req_ready,
    output logic             eject_prod,
    output logic             eject_five,
    output logic             eject_ten,
    input  logic             eject_done,
    input  logic             refill_five,
    input  logic             refill_ten,
    input  logic             clr_fault,
    output logic             busy,
    output logic             fault,
    output logic             txn_done,
    output logic [CNT_W-1:0] five_cnt,
    output logic [CNT_W-1:0] ten_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_PROD, S_WAIT_PROD, S_COIN, S_WAIT_COIN, S_DONE, S_FAULT
    } state_t;

    state_t          r_state;
    logic [1:0]      r_rem;
    logic [TW-1:0]   r_tcnt;

    logic [1:0]       w_rem_req, w_rem_cur, w_rem_after;
    logic             w_accept, w_infeasible, w_wait, w_enter_coin;
    logic             w_pick_ten, w_pick_five, w_dec_five, w_dec_ten;
    logic [CNT_W-1:0] w_five_nxt, w_ten_nxt;

    always_comb begin
        w_rem_req    = (req_chg == 2'b10) ? 2'd2 : (req_chg == 2'b01) ? 2'd1 : 2'd0;
        w_accept     = req_valid && (r_state == S_IDLE);
        w_infeasible = (req_chg == 2'b11)
                    || ((w_rem_req == 2'd1) && (five_cnt == '0))
                    || ((w_rem_req == 2'd2) && (ten_cnt == '0) && (five_cnt < CNT_W'(2)));
        w_wait       = (r_state == S_WAIT_PROD) || (r_state == S_WAIT_COIN);
        // The coin choice is made on the edge that enters COIN, so the decrement lands with the pulse.
        w_rem_cur    = (r_state == S_IDLE) ? w_rem_req : r_rem;
        w_pick_ten   = (w_rem_cur == 2'd2) && (ten_cnt != '0);
        w_pick_five  = (w_rem_cur != 2'd0) && !w_pick_ten;
        w_rem_after  = w_pick_ten ? 2'd0 : (w_rem_cur - 2'd1);
        w_enter_coin = (w_accept && !w_infeasible && !req_prod && (w_rem_req != 2'd0))
                    || (w_wait && eject_done && (r_rem != 2'd0));
        w_dec_five   = w_enter_coin && w_pick_five;
        w_dec_ten    = w_enter_coin && w_pick_ten;

        w_five_nxt = five_cnt;
        if (refill_five && !w_dec_five)
            w_five_nxt = (five_cnt == CNT_MAX) ? five_cnt : five_cnt + 1'b1;
        else if (w_dec_five && !refill_five)
            w_five_nxt = five_cnt - 1'b1;

        w_ten_nxt = ten_cnt;
        if (refill_ten && !w_dec_ten)
            w_ten_nxt = (ten_cnt == CNT_MAX) ? ten_cnt : ten_cnt + 1'b1;
        else if (w_dec_ten && !refill_ten)
            w_ten_nxt = ten_cnt - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rem      <= 2'd0;
            r_tcnt     <= '0;
            five_cnt   <= CNT_W'(INIT_FIVE);
            ten_cnt    <= CNT_W'(INIT_TEN);
            eject_prod <= 1'b0;
            eject_five <= 1'b0;
            eject_ten  <= 1'b0;
            txn_done   <= 1'b0;
            fault      <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            five_cnt   <= w_five_nxt;
            ten_cnt    <= w_ten_nxt;
            eject_prod <= 1'b0;
            eject_five <= 1'b0;
            eject_ten  <= 1'b0;
            txn_done   <= 1'b0;
            fault      <= 1'b0;
            busy       <= 1'b1;
            req_ready  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_infeasible) begin
                            r_state <= S_FAULT;
                            fault   <= 1'b1;
                        end else if (req_prod) begin
                            r_state    <= S_PROD;
                            r_rem      <= w_rem_req;
                            eject_prod <= 1'b1;
                        end else if (w_enter_coin) begin
                            r_state    <= S_COIN;
                            r_rem      <= w_rem_after;
                            eject_ten  <= w_pick_ten;
                            eject_five <= w_pick_five;
                        end else begin
                            r_state  <= S_DONE;
                            txn_done <= 1'b1;
                        end
                    end else begin
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                S_PROD: begin
                    r_state <= S_WAIT_PROD;
                    r_tcnt  <= '0;
                end
                S_COIN: begin
                    r_state <= S_WAIT_COIN;
                    r_tcnt  <= '0;
                end
                S_WAIT_PROD, S_WAIT_COIN: begin
                    if (eject_done) begin
                        if (w_enter_coin) begin
                            r_state    <= S_COIN;
                            r_rem      <= w_rem_after;
                            eject_ten  <= w_pick_ten;
                            eject_five <= w_pick_five;
                        end else begin
                            r_state  <= S_DONE;
                            txn_done <= 1'b1;
                        end
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_state <= S_FAULT;
                        fault   <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_FAULT: begin
                    if (clr_fault) begin
                        r_state   <= S_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        fault <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a transaction-level model predicts every output each cycle,
// and literal checks pin timing, inventory and fault behaviour at chosen points.
module tb_change_dispenser;
    localparam int TIMEOUT = 15;
    localparam int CMAX    = 15;

    logic       clk = 1'b0, rst = 1'b1;
    logic       req_valid = 1'b0, req_prod = 1'b0;
    logic [1:0] req_chg = 2'b00;
    logic       eject_done = 1'b0, refill_five = 1'b0, refill_ten = 1'b0, clr_fault = 1'b0;
    logic       req_ready, eject_prod, eject_five, eject_ten, busy, fault, txn_done;
    logic [3:0] five_cnt, ten_cnt;

    change_dispenser #(.CNT_W(4), .INIT_FIVE(8), .INIT_TEN(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_prod(req_prod), .req_chg(req_chg),
        .req_ready(req_ready), .eject_prod(eject_prod), .eject_five(eject_five), .eject_ten(eject_ten),
        .eject_done(eject_done), .refill_five(refill_five), .refill_ten(refill_ten),
        .clr_fault(clr_fault), .busy(busy), .fault(fault), .txn_done(txn_done),
        .five_cnt(five_cnt), .ten_cnt(ten_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a payout is a list of items, each a pulse followed by a bounded wait.
    localparam int P_IDLE = 0, P_PULSE = 1, P_WAIT = 2, P_DONE = 3, P_FAULT = 4;
    localparam int K_PROD = 0, K_FIVE = 1, K_TEN = 2;
    int m_phase, m_kind, m_rem, m_waited, m_c5, m_c10;
    bit m_pend_prod, m_d5, m_d10;

    function automatic int bump(input int c, input bit inc, input bit dec);
        if (inc && !dec) return (c == CMAX) ? c : c + 1;
        if (dec && !inc) return c - 1;
        return c;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_kind = K_PROD; m_rem = 0; m_waited = 0;
        m_c5 = 8; m_c10 = 8; m_pend_prod = 0;
    endtask

    task automatic model_next_item();
        if (m_pend_prod) begin
            m_kind = K_PROD; m_pend_prod = 0; m_phase = P_PULSE;
        end else if (m_rem == 0) begin
            m_phase = P_DONE;
        end else begin
            if (m_rem == 2 && m_c10 > 0) begin
                m_kind = K_TEN; m_d10 = 1; m_rem = 0;
            end else begin
                m_kind = K_FIVE; m_d5 = 1; m_rem = m_rem - 1;
            end
            m_phase = P_PULSE;
        end
    endtask

    task automatic model_step();
        int rem;
        m_d5 = 0; m_d10 = 0;
        case (m_phase)
            P_IDLE: if (req_valid) begin
                rem = (req_chg == 2'b10) ? 2 : (req_chg == 2'b01) ? 1 : 0;
                if (req_chg == 2'b11 || (rem == 1 && m_c5 == 0) || (rem == 2 && m_c10 == 0 && m_c5 < 2))
                    m_phase = P_FAULT;
                else begin
                    m_pend_prod = req_prod; m_rem = rem; model_next_item();
                end
            end
            P_PULSE: begin m_phase = P_WAIT; m_waited = 0; end
            P_WAIT: if (eject_done) model_next_item();
                    else begin
                        m_waited++;
                        if (m_waited == TIMEOUT) m_phase = P_FAULT;
                    end
            P_DONE:  m_phase = P_IDLE;
            default: if (clr_fault) m_phase = P_IDLE;
        endcase
        m_c5  = bump(m_c5, refill_five, m_d5);
        m_c10 = bump(m_c10, refill_ten, m_d10);
    endtask

    // Compare on the falling edge, then advance the model with the inputs the next rising edge samples.
    initial forever begin
        logic [14:0] act, exp;
        logic [3:0] e5, e10;
        @(negedge clk);
        if (rst) model_reset();
        e5 = m_c5[3:0]; e10 = m_c10[3:0];
        exp = {m_phase == P_IDLE, m_phase != P_IDLE, m_phase == P_FAULT,
               m_phase == P_PULSE && m_kind == K_PROD, m_phase == P_PULSE && m_kind == K_FIVE,
               m_phase == P_PULSE && m_kind == K_TEN, m_phase == P_DONE, e5, e10};
        act = {req_ready, busy, fault, eject_prod, eject_five, eject_ten, txn_done, five_cnt, ten_cnt};
        chk("cycle_outputs", 32'(act), 32'(exp));
        if (!rst) model_step();
    end

    // Mechanism: acknowledges each eject done_delay cycles later (0 = never), and tallies pulses.
    int done_delay = 2;
    int n_prod = 0, n_five = 0, n_ten = 0, n_txn = 0;
    initial begin
        bit pend = 0;
        int k = 0;
        forever begin
            @(posedge clk); #1;
            eject_done = 1'b0;
            if (rst) pend = 0;
            else begin
                if (pend) begin
                    k--;
                    if (k == 0) begin eject_done = 1'b1; pend = 0; end
                end
                if (eject_prod || eject_five || eject_ten) begin
                    pend = (done_delay != 0); k = done_delay;
                end
                n_prod += int'(eject_prod); n_five += int'(eject_five);
                n_ten  += int'(eject_ten);  n_txn  += int'(txn_done);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic clr_tally();
        n_prod = 0; n_five = 0; n_ten = 0; n_txn = 0;
    endtask

    task automatic send(input bit prod, input logic [1:0] chg);
        req_valid = 1'b1; req_prod = prod; req_chg = chg;
        tick();
        req_valid = 1'b0; refill_five = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (req_ready !== 1'b1 && k < 60) begin tick(); k++; end
        chk("reach_idle", 32'(req_ready), 32'd1);
    endtask

    task automatic pulse_clr();
        clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnts", 32'({five_cnt, ten_cnt}), 32'h88);
        rst = 1'b0;
        tick();

        // Product only: pulse at N+1, done at N+3, txn_done at N+4.
        send(1'b1, 2'b00);
        chk("t1_prod_n1", 32'(eject_prod), 32'd1);
        tick(); chk("t1_prod_n2", 32'(eject_prod), 32'd0);
        tick(); chk("t1_txn_n3", 32'(txn_done), 32'd0);
        tick(); chk("t1_txn_n4", 32'(txn_done), 32'd1);
        tick(); chk("t1_ready_n5", 32'(req_ready), 32'd1);
        chk("t1_cnts", 32'({five_cnt, ten_cnt}), 32'h88);

        // Product plus ten.
        clr_tally();
        send(1'b1, 2'b10); wait_idle();
        chk("t2_tally", 32'({n_prod[3:0], n_five[3:0], n_ten[3:0], n_txn[3:0]}), 32'h1011);
        chk("t2_cnts", 32'({five_cnt, ten_cnt}), 32'h87);

        // Drain tens to 0 and fives to 3, then a ten is paid as two fives.
        for (int i = 0; i < 7; i++) begin send(1'b0, 2'b10); wait_idle(); end
        for (int i = 0; i < 5; i++) begin send(1'b0, 2'b01); wait_idle(); end
        chk("t3_pre", 32'({five_cnt, ten_cnt}), 32'h30);
        clr_tally();
        send(1'b0, 2'b10); wait_idle();
        chk("t3_tally", 32'({n_prod[3:0], n_five[3:0], n_ten[3:0], n_txn[3:0]}), 32'h0201);
        chk("t3_cnts", 32'({five_cnt, ten_cnt}), 32'h10);

        // One five and no ten cannot make ten: fault, nothing dispensed.
        clr_tally();
        send(1'b1, 2'b10);
        chk("t4_fault", 32'({fault, req_ready}), 32'b10);
        repeat (3) tick();
        chk("t4_sticky", 32'(fault), 32'd1);
        chk("t4_noeject", 32'(n_prod + n_five + n_ten), 32'd0);
        pulse_clr();
        chk("t4_clr", 32'({fault, req_ready}), 32'b01);

        send(1'b0, 2'b01); wait_idle();
        chk("t4_five0", 32'(five_cnt), 32'd0);
        clr_tally();
        send(1'b1, 2'b01);
        chk("t4b_fault", 32'({fault, req_ready, eject_prod}), 32'b100);
        refill_five = 1'b1; tick(); refill_five = 1'b0;
        chk("t4b_refill", 32'({fault, five_cnt}), 32'h11);
        chk("t4b_noprod", 32'(n_prod), 32'd0);
        pulse_clr();
        send(1'b0, 2'b11);
        chk("t4c_illegal", 32'(fault), 32'd1);
        pulse_clr();

        // Done on the last allowed wait cycle succeeds; a request while busy is ignored.
        done_delay = TIMEOUT; clr_tally();
        send(1'b1, 2'b00);
        repeat (3) tick();
        req_valid = 1'b1; req_chg = 2'b11; tick(); req_valid = 1'b0; req_chg = 2'b00;
        wait_idle();
        chk("t5_edge", 32'({fault, n_txn[3:0]}), 32'h01);

        // Withheld done: fault exactly TIMEOUT cycles into the wait, then reset mid-fault.
        done_delay = 0;
        send(1'b1, 2'b00);
        repeat (TIMEOUT) tick();
        chk("t5_before", 32'(fault), 32'd0);
        tick();
        chk("t5_timeout", 32'(fault), 32'd1);
        rst = 1'b1; #1;
        chk("t5_rst", 32'({req_ready, busy, fault, eject_prod, eject_five, eject_ten, txn_done, five_cnt, ten_cnt}),
            32'({7'b1000000, 4'd8, 4'd8}));
        tick(); rst = 1'b0; tick();
        done_delay = 2;

        // Saturation and refill coincident with a five decrement.
        refill_five = 1'b1; repeat (8) tick(); refill_five = 1'b0;
        chk("t6_sat", 32'(five_cnt), 32'd15);
        send(1'b0, 2'b01); wait_idle();
        chk("t6_dec", 32'(five_cnt), 32'd14);
        refill_five = 1'b1;
        send(1'b0, 2'b01);
        chk("t6_coinc", 32'({eject_five, five_cnt}), 32'h1e);
        wait_idle();
        chk("t6_after", 32'(five_cnt), 32'd14);
        refill_ten = 1'b1; tick(); refill_ten = 1'b0;
        chk("t6_ten", 32'(ten_cnt), 32'd9);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
